tlb_ctrl: RTL and testbench

Clocked, parametrised, fully associative TLB with true-LRU replacement. It sits between the CPU-side address port and the page-table walker / page-table memory. Hits are translated in one cycle. On a miss, the block writes back the victim's dirty and reference status if the victim is dirty, requests the missing PPN, fills the entry and responds. Page faults reported by the walker propagate to the requester without filling an entry.

---
 rtl/tlb_ctrl_if.sv | 53 +++++
 rtl/tlb_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_tlb_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_ctrl_if.sv
// -----------------------------------------------------------------------------
// tlb_ctrl_if
// Bundles the CPU-side translation port, the victim status write-back port and
// the page-table walker port of tlb_ctrl.
//
// Parameters: VPN_W (virtual page number width), PPN_W (physical page number
// width), OFF_W (page offset width).
// Modports:
//   slave  - the TLB: takes requests, drives responses, write-back and
//            page-table requests.
//   master - the surrounding system: CPU, write-back sink and walker.
// -----------------------------------------------------------------------------
interface tlb_ctrl_if #(
    parameter int VPN_W = 6,
    parameter int PPN_W = 2,
    parameter int OFF_W = 8
);
    // CPU side
    logic                     flush;
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [VPN_W+OFF_W-1:0]   req_vaddr;
    logic                     resp_valid;
    logic                     resp_hit;
    logic                     resp_fault;
    logic [PPN_W+OFF_W-1:0]   resp_paddr;
    // Victim status write-back
    logic                     wb_valid;
    logic                     wb_ready;
    logic [VPN_W-1:0]         wb_vpn;
    logic [1:0]               wb_dirty_ref;
    // Page-table walker
    logic                     pt_req_valid;
    logic [VPN_W-1:0]         pt_req_vpn;
    logic                     pt_resp_valid;
    logic [PPN_W-1:0]         pt_resp_ppn;
    logic                     pt_resp_fault;

    modport slave (
        input  flush, req_valid, req_write, req_vaddr,
        input  wb_ready, pt_resp_valid, pt_resp_ppn, pt_resp_fault,
        output req_ready, resp_valid, resp_hit, resp_fault, resp_paddr,
        output wb_valid, wb_vpn, wb_dirty_ref, pt_req_valid, pt_req_vpn
    );

    modport master (
        output flush, req_valid, req_write, req_vaddr,
        output wb_ready, pt_resp_valid, pt_resp_ppn, pt_resp_fault,
        input  req_ready, resp_valid, resp_hit, resp_fault, resp_paddr,
        input  wb_valid, wb_vpn, wb_dirty_ref, pt_req_valid, pt_req_vpn
    );
endinterface

// File: rtl/tlb_ctrl.sv
// -----------------------------------------------------------------------------
// tlb_ctrl
// Fully associative TLB with true-LRU replacement. Hits translate in one cycle;
// misses write back a dirty victim's status, ask the page-table walker for the
// PPN, fill the victim entry and respond. Walker faults are passed on to the
// requester and leave the victim entry invalid.
//
// Ports:
//   clk   - clock, all state changes on the rising edge
//   reset - asynchronous, active-high; clears all state and outputs
//   bus   - tlb_ctrl_if.slave: request/response, write-back and walker ports
// -----------------------------------------------------------------------------
module tlb_ctrl #(
    parameter int ENTRIES = 4,
    parameter int VPN_W   = 6,
    parameter int PPN_W   = 2,
    parameter int OFF_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    tlb_ctrl_if.slave   bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(ENTRIES - 1);

    typedef enum logic [1:0] {IDLE, WB, WALK, RESP} state_e;

    state_e                 state_q;

    // Entry storage. Age 0 is most recently used, ENTRIES-1 least recently used.
    logic [ENTRIES-1:0]     valid_q;
    logic [ENTRIES-1:0]     dirty_q;
    logic [ENTRIES-1:0]     ref_q;
    logic [VPN_W-1:0]       tag_q [ENTRIES];
    logic [PPN_W-1:0]       ppn_q [ENTRIES];
    logic [IDX_W-1:0]       age_q [ENTRIES];

    // Miss context captured at accept time.
    logic [VPN_W-1:0]       vpn_q;
    logic [OFF_W-1:0]       off_q;
    logic                   write_q;
    logic [IDX_W-1:0]       victim_q;

    // Registered outputs.
    logic                   resp_valid_q;
    logic                   resp_hit_q;
    logic                   resp_fault_q;
    logic [PPN_W+OFF_W-1:0] resp_paddr_q;
    logic                   wb_valid_q;
    logic [VPN_W-1:0]       wb_vpn_q;
    logic [1:0]             wb_dirty_ref_q;
    logic                   pt_req_valid_q;
    logic [VPN_W-1:0]       pt_req_vpn_q;

    logic [VPN_W-1:0]       req_vpn;
    logic [OFF_W-1:0]       req_off;
    logic                   accept;
    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic                   inv_any;
    logic [IDX_W-1:0]       inv_idx;
    logic [IDX_W-1:0]       lru_idx;
    logic [IDX_W-1:0]       victim_idx;

    assign req_vpn       = bus.req_vaddr[VPN_W+OFF_W-1:OFF_W];
    assign req_off       = bus.req_vaddr[OFF_W-1:0];
    assign bus.req_ready = (state_q == IDLE) && !bus.flush;
    assign accept        = bus.req_valid && bus.req_ready;

    // Access update: the touched entry becomes MRU, every entry that was
    // younger than it ages by one.
    function automatic logic [IDX_W-1:0] next_age(
        input logic [IDX_W-1:0] age,
        input logic             touched,
        input logic [IDX_W-1:0] old_age
    );
        if (touched)            return '0;
        else if (age < old_age) return age + 1'b1;
        else                    return age;
    endfunction

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        inv_any = 1'b0;
        inv_idx = '0;
        lru_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == req_vpn) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (age_q[i] == AGE_MAX) lru_idx = IDX_W'(i);
        end
        // Scan downwards so the lowest invalid index is the one left standing.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                inv_any = 1'b1;
                inv_idx = IDX_W'(i);
            end
        end
        victim_idx = inv_any ? inv_idx : lru_idx;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            // NOTE: the entry array is reset explicitly: the valid bits and
            // the age permutation must be defined before the first lookup.
            valid_q        <= '0;
            dirty_q        <= '0;
            ref_q          <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                ppn_q[i] <= '0;
                age_q[i] <= IDX_W'(i);
            end
            vpn_q          <= '0;
            off_q          <= '0;
            write_q        <= 1'b0;
            victim_q       <= '0;
            resp_valid_q   <= 1'b0;
            resp_hit_q     <= 1'b0;
            resp_fault_q   <= 1'b0;
            resp_paddr_q   <= '0;
            wb_valid_q     <= 1'b0;
            wb_vpn_q       <= '0;
            wb_dirty_ref_q <= '0;
            pt_req_valid_q <= 1'b0;
            pt_req_vpn_q   <= '0;
        end else begin
            // Response fields are single-cycle pulses.
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_paddr_q <= '0;

            case (state_q)
                IDLE: begin
                    if (bus.flush) begin
                        valid_q <= '0;
                        dirty_q <= '0;
                        ref_q   <= '0;
                        for (int i = 0; i < ENTRIES; i++) age_q[i] <= IDX_W'(i);
                    end else if (accept && hit) begin
                        ref_q[hit_idx] <= 1'b1;
                        if (bus.req_write) dirty_q[hit_idx] <= 1'b1;
                        for (int i = 0; i < ENTRIES; i++)
                            age_q[i] <= next_age(age_q[i], hit_idx == IDX_W'(i), age_q[hit_idx]);
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= 1'b1;
                        resp_paddr_q <= {ppn_q[hit_idx], req_off};
                    end else if (accept) begin
                        vpn_q    <= req_vpn;
                        off_q    <= req_off;
                        write_q  <= bus.req_write;
                        victim_q <= victim_idx;
                        if (valid_q[victim_idx] && dirty_q[victim_idx]) begin
                            wb_valid_q     <= 1'b1;
                            wb_vpn_q       <= tag_q[victim_idx];
                            wb_dirty_ref_q <= {dirty_q[victim_idx], ref_q[victim_idx]};
                            state_q        <= WB;
                        end else begin
                            pt_req_valid_q <= 1'b1;
                            pt_req_vpn_q   <= req_vpn;
                            state_q        <= WALK;
                        end
                    end
                end
                WB: begin
                    if (bus.wb_ready) begin
                        wb_valid_q     <= 1'b0;
                        pt_req_valid_q <= 1'b1;
                        pt_req_vpn_q   <= vpn_q;
                        state_q        <= WALK;
                    end
                end
                WALK: begin
                    if (bus.pt_resp_valid) begin
                        pt_req_valid_q <= 1'b0;
                        resp_valid_q   <= 1'b1;
                        resp_fault_q   <= bus.pt_resp_fault;
                        if (bus.pt_resp_fault) begin
                            // The old mapping is already gone; ages stay put so
                            // the hole is refilled first by the next miss.
                            valid_q[victim_q] <= 1'b0;
                            dirty_q[victim_q] <= 1'b0;
                            ref_q[victim_q]   <= 1'b0;
                        end else begin
                            valid_q[victim_q] <= 1'b1;
                            dirty_q[victim_q] <= write_q;
                            ref_q[victim_q]   <= 1'b1;
                            tag_q[victim_q]   <= vpn_q;
                            ppn_q[victim_q]   <= bus.pt_resp_ppn;
                            // A fill is treated as touching the oldest slot.
                            for (int i = 0; i < ENTRIES; i++)
                                age_q[i] <= next_age(age_q[i], victim_q == IDX_W'(i), AGE_MAX);
                            resp_paddr_q <= {bus.pt_resp_ppn, off_q};
                        end
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_hit     = resp_hit_q;
    assign bus.resp_fault   = resp_fault_q;
    assign bus.resp_paddr   = resp_paddr_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_vpn       = wb_vpn_q;
    assign bus.wb_dirty_ref = wb_dirty_ref_q;
    assign bus.pt_req_valid = pt_req_valid_q;
    assign bus.pt_req_vpn   = pt_req_vpn_q;
endmodule

// File: tb/tb_tlb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tlb_ctrl
// Directed bench for tlb_ctrl. The default instance (4 entries, 6-bit VPN,
// 2-bit PPN) covers cold miss, hit, LRU eviction, dirty write-back, page fault,
// flush and reset-during-walk. A second instance (8 entries, 10-bit VPN, 6-bit
// PPN) runs a 9-VPN cyclic pattern that must miss on every access.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_tlb_ctrl;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    tlb_ctrl_if #(.VPN_W(6),  .PPN_W(2), .OFF_W(8)) bus  ();
    tlb_ctrl_if #(.VPN_W(10), .PPN_W(6), .OFF_W(8)) bus8 ();

    tlb_ctrl #(.ENTRIES(4), .VPN_W(6), .PPN_W(2), .OFF_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    tlb_ctrl #(.ENTRIES(8), .VPN_W(10), .PPN_W(6), .OFF_W(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Present one request for one cycle; returns at the falling edge of the
    // cycle after the accepting edge.
    task automatic issue(input logic [13:0] addr, input logic wr, input string tag);
        @(negedge clk);
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_vaddr = addr;
        bus.req_write = wr;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
    endtask

    task automatic hit(input logic [13:0] addr, input logic wr, input logic [9:0] exp_pa,
                       input string tag);
        issue(addr, wr, tag);
        check({tag, "_rv"},  32'(bus.resp_valid), 32'd1);
        check({tag, "_hit"}, 32'(bus.resp_hit),   32'd1);
        check({tag, "_pa"},  32'(bus.resp_paddr), 32'(exp_pa));
    endtask

    // Called at a falling edge where pt_req_valid must already be high.
    task automatic walk(input logic [5:0] exp_vpn, input int delay, input logic [1:0] ppn,
                        input logic fault, input logic [9:0] exp_pa, input string tag);
        check({tag, "_ptv"},   32'(bus.pt_req_valid), 32'd1);
        check({tag, "_ptvpn"}, 32'(bus.pt_req_vpn),   32'(exp_vpn));
        repeat (delay) begin
            @(negedge clk);
            check({tag, "_ptv_hold"}, 32'(bus.pt_req_valid), 32'd1);
        end
        bus.pt_resp_valid = 1'b1;
        bus.pt_resp_ppn   = ppn;
        bus.pt_resp_fault = fault;
        @(negedge clk);
        bus.pt_resp_valid = 1'b0;
        bus.pt_resp_fault = 1'b0;
        check({tag, "_rv"},    32'(bus.resp_valid),   32'd1);
        check({tag, "_hit"},   32'(bus.resp_hit),     32'd0);
        check({tag, "_fault"}, 32'(bus.resp_fault),   32'(fault));
        check({tag, "_pa"},    32'(bus.resp_paddr),   32'(exp_pa));
        check({tag, "_ptv0"},  32'(bus.pt_req_valid), 32'd0);
        @(negedge clk);
        check({tag, "_rv0"},   32'(bus.resp_valid),   32'd0);
        check({tag, "_rdy"},   32'(bus.req_ready),    32'd1);
    endtask

    task automatic miss(input logic [13:0] addr, input logic wr, input logic [1:0] ppn,
                        input logic fault, input int delay, input logic [9:0] exp_pa,
                        input string tag);
        issue(addr, wr, tag);
        check({tag, "_wbv"},   32'(bus.wb_valid),   32'd0);
        check({tag, "_nohit"}, 32'(bus.resp_valid), 32'd0);
        walk(addr[13:8], delay, ppn, fault, exp_pa, tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [13:0] a;
        logic [9:0]  pa;
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        bus.flush = 1'b0;  bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_vaddr = '0;
        bus.wb_ready = 1'b0; bus.pt_resp_valid = 1'b0; bus.pt_resp_ppn = '0;
        bus.pt_resp_fault = 1'b0;
        bus8.flush = 1'b0; bus8.req_valid = 1'b0; bus8.req_write = 1'b0; bus8.req_vaddr = '0;
        bus8.wb_ready = 1'b0; bus8.pt_resp_valid = 1'b0; bus8.pt_resp_ppn = '0;
        bus8.pt_resp_fault = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_ready", 32'(bus.req_ready),    32'd1);
        check("rst_rv",    32'(bus.resp_valid),   32'd0);
        check("rst_wbv",   32'(bus.wb_valid),     32'd0);
        check("rst_ptv",   32'(bus.pt_req_valid), 32'd0);
        check("rst_pa",    32'(bus.resp_paddr),   32'd0);

        // Cold miss, walker answers after one cycle, then a hit on the same page
        miss(14'h0A5C, 1'b0, 2'd2, 1'b0, 1, 10'h25C, "cold");
        hit(14'h0A5C, 1'b0, 10'h25C, "cold_hit");

        // LRU fill and evict: vpns 1..4 fill 0..3, touch 1,3,4, vpn 5 evicts vpn 2
        do_reset();
        for (int v = 1; v <= 4; v++) begin
            a  = {6'(v), 8'h11};
            pa = {2'(v), 8'h11};
            miss(a, 1'b0, 2'(v), 1'b0, 0, pa, "fill");
        end
        hit(14'h0111, 1'b0, 10'h111, "touch1");
        hit(14'h0311, 1'b0, 10'h311, "touch3");
        hit(14'h0411, 1'b0, 10'h011, "touch4");
        miss(14'h0511, 1'b0, 2'd1, 1'b0, 0, 10'h111, "miss5");
        hit(14'h0111, 1'b0, 10'h111, "kept1");
        hit(14'h0311, 1'b0, 10'h311, "kept3");
        hit(14'h0411, 1'b0, 10'h011, "kept4");
        miss(14'h0211, 1'b0, 2'd2, 1'b0, 0, 10'h211, "rewalk2");

        // Dirty write-back: store to vpn 1, fill with 2..4, vpn 1 is then LRU
        do_reset();
        miss(14'h01AB, 1'b1, 2'd1, 1'b0, 0, 10'h1AB, "st1");
        for (int v = 2; v <= 4; v++) begin
            a  = {6'(v), 8'h11};
            pa = {2'(v), 8'h11};
            miss(a, 1'b0, 2'(v), 1'b0, 0, pa, "fill_d");
        end
        issue(14'h0640, 1'b0, "dirty");
        check("dirty_wbv",   32'(bus.wb_valid),     32'd1);
        check("dirty_wbvpn", 32'(bus.wb_vpn),       32'd1);
        check("dirty_wbdr",  32'(bus.wb_dirty_ref), 32'b11);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check("dirty_hold_wbv", 32'(bus.wb_valid),     32'd1);
            check("dirty_hold_ptv", 32'(bus.pt_req_valid), 32'd0);
            check("dirty_hold_vpn", 32'(bus.wb_vpn),       32'd1);
        end
        @(negedge clk);
        bus.wb_ready = 1'b1;
        check("dirty_w_ptv", 32'(bus.pt_req_valid), 32'd0);
        @(negedge clk);
        bus.wb_ready = 1'b0;
        check("dirty_wb_drop", 32'(bus.wb_valid), 32'd0);
        walk(6'd6, 0, 2'd3, 1'b0, 10'h340, "dirty_walk");

        // Page fault on vpn 0x3F, then the same vpn must walk again
        miss(14'h3F00, 1'b0, 2'd0, 1'b1, 0, 10'h000, "fault");
        miss(14'h3F00, 1'b0, 2'd1, 1'b0, 0, 10'h100, "fault_rewalk");

        // Flush together with a request: not accepted, vpn 6 then misses
        @(negedge clk);
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_vaddr = 14'h0640;
        #1 check("flush_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        check("flush_rv",  32'(bus.resp_valid),   32'd0);
        check("flush_ptv", 32'(bus.pt_req_valid), 32'd0);
        miss(14'h0640, 1'b0, 2'd3, 1'b0, 0, 10'h340, "post_flush");

        // Reset during WALK: strobes drop at once, no response ever appears
        issue(14'h1000, 1'b0, "rst_walk");
        check("rst_walk_ptv", 32'(bus.pt_req_valid), 32'd1);
        #2 reset = 1'b1;
        bus.pt_resp_valid = 1'b1;
        #1 check("rst_walk_drop", 32'(bus.pt_req_valid), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("rst_walk_rv", 32'(bus.resp_valid), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        bus.pt_resp_valid = 1'b0;
        check("rst_after_rv",  32'(bus.resp_valid),   32'd0);
        check("rst_after_ptv", 32'(bus.pt_req_valid), 32'd0);
        check("rst_after_rdy", 32'(bus.req_ready),    32'd1);
        @(negedge clk);
        check("rst_after_rv2", 32'(bus.resp_valid),   32'd0);

        // 8-entry instance: 9 distinct vpns cycled twice, every access misses
        for (int r = 0; r < 2; r++) begin
            for (int v = 0; v < 9; v++) begin
                @(negedge clk);
                check("sweep_ready", 32'(bus8.req_ready), 32'd1);
                bus8.req_valid = 1'b1;
                bus8.req_vaddr = {10'(v + 'h200), 8'h00};
                @(negedge clk);
                bus8.req_valid = 1'b0;
                check("sweep_miss", 32'(bus8.pt_req_valid), 32'd1);
                bus8.pt_resp_valid = 1'b1;
                bus8.pt_resp_ppn   = 6'(v);
                @(negedge clk);
                bus8.pt_resp_valid = 1'b0;
                check("sweep_rv",  32'(bus8.resp_valid), 32'd1);
                check("sweep_hit", 32'(bus8.resp_hit),   32'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
